// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions used by both the matrix driver and the panel-side receiver.
package hub75_pkg;

  localparam int COLS        = 32;
  localparam int HALF_ROWS   = 16;
  localparam int SYNC_STAGES = 2;

  typedef logic [2:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/hub75_sync.sv
// N-bit multi-stage input synchroniser; rise/fall are registered so they line up
// with the cycle in which q first shows the new value.
module hub75_sync #(
  parameter int N      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] stage_r [STAGES];
  logic [N-1:0] rise_r;
  logic [N-1:0] fall_r;

  // Synchroniser chain plus edge flags computed from the last two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= '0;
      end
      rise_r <= '0;
      fall_r <= '0;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
      rise_r <= stage_r[STAGES-2] & ~stage_r[STAGES-1];
      fall_r <= ~stage_r[STAGES-2] & stage_r[STAGES-1];
    end
  end

  assign q    = stage_r[STAGES-1];
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/hub75_panel_rx.sv
// Panel end of the HUB75 shift/latch/blank protocol: deserialises latched lines
// into a 32x32 RGB capture memory with registered random-access readback.
module hub75_panel_rx
  import hub75_pkg::*;
#(
  parameter int COLS        = hub75_pkg::COLS,
  parameter int HALF_ROWS   = hub75_pkg::HALF_ROWS,
  parameter int SYNC_STAGES = hub75_pkg::SYNC_STAGES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hub_clk,
  input  logic [2:0]  rgb1,
  input  logic [2:0]  rgb2,
  input  logic [3:0]  row_addr,
  input  logic        lat,
  input  logic        oe,
  input  logic [4:0]  rd_row,
  input  logic [4:0]  rd_col,
  output logic [2:0]  rd_rgb,
  output logic        line_done,
  output logic [3:0]  line_row,
  output logic        len_err,
  output logic        overrun,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        disp_on,
  output logic [3:0]  disp_row
);

  localparam int          DEPTH    = HALF_ROWS * COLS;
  localparam logic [5:0]  COLS_CNT = 6'(COLS);
  localparam logic [5:0]  CNT_SAT  = 6'd63;
  localparam logic [4:0]  COL_LAST = 5'(COLS - 1);
  localparam logic [3:0]  ROW_LAST = 4'(HALF_ROWS - 1);

  logic [2:0] ctrl_q_s, ctrl_rise_s, ctrl_fall_s;
  logic [9:0] data_q_s, data_rise_unused_s, data_fall_unused_s;
  logic [4:0] ctrl_unused_s;
  logic       hub_rise_s, lat_rise_s, oe_fall_s, oe_q_s;
  rgb_t       rgb1_q_s, rgb2_q_s;
  logic [3:0] row_q_s;

  hub75_sync #(.N(3), .STAGES(SYNC_STAGES)) u_ctrl_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({oe, lat, hub_clk}),
    .q    (ctrl_q_s),
    .rise (ctrl_rise_s),
    .fall (ctrl_fall_s)
  );

  hub75_sync #(.N(10), .STAGES(SYNC_STAGES)) u_data_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({row_addr, rgb2, rgb1}),
    .q    (data_q_s),
    .rise (data_rise_unused_s),
    .fall (data_fall_unused_s)
  );

  assign hub_rise_s    = ctrl_rise_s[0];
  assign lat_rise_s    = ctrl_rise_s[1];
  assign oe_fall_s     = ctrl_fall_s[2];
  assign oe_q_s        = ctrl_q_s[2];
  assign ctrl_unused_s = {ctrl_rise_s[2], ctrl_fall_s[1:0], ctrl_q_s[1:0]};
  assign rgb1_q_s      = data_q_s[2:0];
  assign rgb2_q_s      = data_q_s[5:3];
  assign row_q_s       = data_q_s[9:6];

  rgb_t [COLS-1:0] top_sr_r, bot_sr_r, top_sr_nx_s, bot_sr_nx_s;
  rgb_t [COLS-1:0] hold_top_r, hold_bot_r;
  logic [5:0]      shift_cnt_r, cnt_nx_s;
  rx_state_t       state_r;
  logic [4:0]      col_r;
  logic [3:0]      line_row_r;
  logic            first_r;
  logic            line_done_r, len_err_r, overrun_r, frame_done_r;
  logic [15:0]     frame_count_r;
  logic            disp_on_r;
  logic [3:0]      disp_row_r;
  rgb_t            rd_rgb_r;
  rgb_t            mem_top_r [DEPTH];
  rgb_t            mem_bot_r [DEPTH];

  // Post-shift view of the chains, so a same-cycle latch sees the new pixel.
  always_comb begin
    top_sr_nx_s = top_sr_r;
    bot_sr_nx_s = bot_sr_r;
    cnt_nx_s    = shift_cnt_r;
    if (hub_rise_s) begin
      top_sr_nx_s = {top_sr_r[COLS-2:0], rgb1_q_s};
      bot_sr_nx_s = {bot_sr_r[COLS-2:0], rgb2_q_s};
      if (shift_cnt_r != CNT_SAT) begin
        cnt_nx_s = shift_cnt_r + 6'd1;
      end else begin
        cnt_nx_s = shift_cnt_r;
      end
    end else begin
      top_sr_nx_s = top_sr_r;
      bot_sr_nx_s = bot_sr_r;
    end
  end

  // Shift chains and saturating shift counter, cleared by every latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_sr_r    <= '0;
      bot_sr_r    <= '0;
      shift_cnt_r <= 6'd0;
    end else begin
      top_sr_r    <= top_sr_nx_s;
      bot_sr_r    <= bot_sr_nx_s;
      shift_cnt_r <= lat_rise_s ? 6'd0 : cnt_nx_s;
    end
  end

  // Latch/write-out FSM with its status pulses and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      col_r         <= 5'd0;
      hold_top_r    <= '0;
      hold_bot_r    <= '0;
      line_row_r    <= 4'd0;
      first_r       <= 1'b1;
      line_done_r   <= 1'b0;
      len_err_r     <= 1'b0;
      overrun_r     <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      line_done_r  <= 1'b0;
      len_err_r    <= 1'b0;
      overrun_r    <= 1'b0;
      frame_done_r <= 1'b0;
      if (lat_rise_s) begin
        len_err_r <= ~first_r & (cnt_nx_s != COLS_CNT);
        first_r   <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (lat_rise_s) begin
            hold_top_r <= top_sr_nx_s;
            hold_bot_r <= bot_sr_nx_s;
            line_row_r <= row_q_s;
            col_r      <= 5'd0;
            state_r    <= WRITE;
          end
        end
        WRITE: begin
          overrun_r <= lat_rise_s;
          if (col_r == COL_LAST) begin
            state_r <= DONE;
          end else begin
            col_r <= col_r + 5'd1;
          end
        end
        DONE: begin
          overrun_r   <= lat_rise_s;
          line_done_r <= 1'b1;
          if (line_row_r == ROW_LAST) begin
            frame_done_r  <= 1'b1;
            frame_count_r <= frame_count_r + 16'd1;
          end
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Capture memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state_r == WRITE) begin
      mem_top_r[{line_row_r, col_r}] <= hold_top_r[col_r];
      mem_bot_r[{line_row_r, col_r}] <= hold_bot_r[col_r];
    end
  end

  // Registered readback; same-cycle write to the address returns old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_rgb_r <= 3'd0;
    end else if (rd_row[4]) begin
      rd_rgb_r <= mem_bot_r[{rd_row[3:0], rd_col}];
    end else begin
      rd_rgb_r <= mem_top_r[{rd_row[3:0], rd_col}];
    end
  end

  // Display status: row on screen is the one present when blanking ended.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_on_r  <= 1'b0;
      disp_row_r <= 4'd0;
    end else begin
      disp_on_r <= ~oe_q_s;
      if (oe_fall_s) begin
        disp_row_r <= row_q_s;
      end
    end
  end

  assign rd_rgb      = rd_rgb_r;
  assign line_done   = line_done_r;
  assign line_row    = line_row_r;
  assign len_err     = len_err_r;
  assign overrun     = overrun_r;
  assign frame_done  = frame_done_r;
  assign frame_count = frame_count_r;
  assign disp_on     = disp_on_r;
  assign disp_row    = disp_row_r;

endmodule

// File: tb/tb_hub75_panel_rx.sv
// Directed bench for hub75_panel_rx: table-driven readback vectors plus hand-written
// sequences for latch length, overrun, blanking and reset-during-write corners.
module tb_hub75_panel_rx;

  logic        clk = 1'b0;
  logic        reset, hub_clk, lat, oe;
  logic [2:0]  rgb1, rgb2;
  logic [3:0]  row_addr;
  logic [4:0]  rd_row, rd_col;
  logic [2:0]  rd_rgb;
  logic        line_done, len_err, overrun, frame_done, disp_on;
  logic [3:0]  line_row, disp_row;
  logic [15:0] frame_count;

  hub75_panel_rx dut (
    .clk(clk), .reset(reset), .hub_clk(hub_clk), .rgb1(rgb1), .rgb2(rgb2),
    .row_addr(row_addr), .lat(lat), .oe(oe), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb(rd_rgb), .line_done(line_done), .line_row(line_row), .len_err(len_err),
    .overrun(overrun), .frame_done(frame_done), .frame_count(frame_count),
    .disp_on(disp_on), .disp_row(disp_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] row;
    logic [4:0] col;
    logic [2:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_ld = 0, n_fd = 0, n_le = 0, n_ov = 0;

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (line_done)  n_ld <= n_ld + 1;
    if (frame_done) n_fd <= n_fd + 1;
    if (len_err)    n_le <= n_le + 1;
    if (overrun)    n_ov <= n_ov + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pixel(input logic [2:0] a, input logic [2:0] b);
    rgb1 = a;
    rgb2 = b;
    cyc(2);
    hub_clk = 1'b1;
    cyc(2);
    hub_clk = 1'b0;
  endtask

  task automatic lat_pulse();
    lat = 1'b1;
    cyc(2);
    lat = 1'b0;
  endtask

  task automatic wait_ld(input int base, input string name);
    int k;
    k = 0;
    while (n_ld == base && k < 80) begin
      cyc(1);
      k++;
    end
    check(name, 32'(n_ld - base), 32'd1);
  endtask

  task automatic run_vecs(input string name);
    foreach (vecs[i]) begin
      rd_row = vecs[i].row;
      rd_col = vecs[i].col;
      cyc(1);
      check($sformatf("%s r%0d c%0d", name, vecs[i].row, vecs[i].col), 32'(rd_rgb), 32'(vecs[i].exp));
    end
    vecs.delete();
  endtask

  function automatic logic [31:0] all_outs();
    return {rd_rgb, line_done, line_row, len_err, overrun, frame_done, frame_count, disp_on, disp_row};
  endfunction

  initial begin
    int n, base, le0, ov0;
    logic [4:0] t, r5, c5;
    logic [2:0] p;

    reset = 1'b1; hub_clk = 1'b0; lat = 1'b0; oe = 1'b0;
    rgb1 = 3'd0; rgb2 = 3'd0; row_addr = 4'd0; rd_row = 5'd0; rd_col = 5'd0;
    cyc(3);
    check("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    cyc(4);

    // Single line on row 5; first-shifted pixel ends up in the last column.
    row_addr = 4'd5;
    for (int k = 0; k < 32; k++) begin
      t = 5'(k);
      pixel(t[2:0], ~t[2:0]);
    end
    base = n_ld;
    lat = 1'b1;
    n = 0;
    while (n_ld == base && n < 100) begin
      cyc(1);
      n++;
      if (n == 2) lat = 1'b0;
    end
    check("line_done_latency", ((n - 2) >= 33 && (n - 2) <= 35) ? 32'd1 : 32'd0, 32'd1);
    check("single_line_row", 32'(line_row), 32'd5);
    check("single_no_len_err", 32'(n_le), 32'd0);
    for (int c = 0; c < 32; c++) begin
      t = 5'(31 - c);
      vecs.push_back('{5'd5, 5'(c), t[2:0]});
      vecs.push_back('{5'd21, 5'(c), ~t[2:0]});
    end
    run_vecs("single");

    // Three full frames of {row[0], col[0], 1}.
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 16; r++) begin
        row_addr = 4'(r);
        r5 = 5'(r);
        for (int k = 0; k < 32; k++) begin
          c5 = 5'(31 - k);
          p = {r5[0], c5[0], 1'b1};
          pixel(p, p);
        end
        base = n_ld;
        lat_pulse();
        wait_ld(base, "frame_line_done");
      end
    end
    check("frame_done_pulses", 32'(n_fd), 32'd3);
    check("frame_count", 32'(frame_count), 32'd3);
    check("frame_last_row", 32'(line_row), 32'd15);
    check("full_lines_no_len_err", 32'(n_le), 32'd0);
    for (int rr = 0; rr < 32; rr++) begin
      for (int c = 0; c < 32; c++) begin
        r5 = 5'(rr);
        c5 = 5'(c);
        vecs.push_back('{r5, c5, {r5[0], c5[0], 1'b1}});
      end
    end
    run_vecs("frame");

    // Short (31) and long (33) lines still get written but flag len_err.
    row_addr = 4'd7;
    le0 = n_le;
    for (int k = 0; k < 31; k++) pixel(3'b101, 3'b010);
    base = n_ld;
    lat_pulse();
    wait_ld(base, "short_line_done");
    check("len_err_31", 32'(n_le - le0), 32'd1);
    vecs.push_back('{5'd7, 5'd0, 3'b101});
    vecs.push_back('{5'd7, 5'd30, 3'b101});
    vecs.push_back('{5'd23, 5'd0, 3'b010});
    vecs.push_back('{5'd23, 5'd30, 3'b010});
    run_vecs("short");
    for (int k = 0; k < 33; k++) pixel(3'b011, 3'b100);
    base = n_ld;
    lat_pulse();
    wait_ld(base, "long_line_done");
    check("len_err_33", 32'(n_le - le0), 32'd2);

    // Overrun: second latch 10 cycles after the first while still writing.
    row_addr = 4'd3;
    for (int k = 0; k < 32; k++) pixel(3'b110, 3'b001);
    base = n_ld;
    ov0 = n_ov;
    lat_pulse();
    row_addr = 4'd4;
    pixel(3'b001, 3'b110);
    pixel(3'b001, 3'b110);
    lat_pulse();
    cyc(60);
    check("overrun_pulse", 32'(n_ov - ov0), 32'd1);
    check("overrun_one_line_done", 32'(n_ld - base), 32'd1);
    check("overrun_line_row", 32'(line_row), 32'd3);
    vecs.push_back('{5'd3, 5'd0, 3'b110});
    vecs.push_back('{5'd3, 5'd1, 3'b110});
    vecs.push_back('{5'd3, 5'd31, 3'b110});
    vecs.push_back('{5'd19, 5'd0, 3'b001});
    vecs.push_back('{5'd4, 5'd1, 3'b011});
    run_vecs("overrun");

    // Blanking: disp_row captured on oe fall, disp_on follows ~oe.
    oe = 1'b1;
    row_addr = 4'd9;
    cyc(5);
    check("disp_on_blanked", 32'(disp_on), 32'd0);
    oe = 1'b0;
    cyc(2);
    check("disp_on_early", 32'(disp_on), 32'd0);
    cyc(1);
    check("disp_on_after_fall", 32'(disp_on), 32'd1);
    check("disp_row_after_fall", 32'(disp_row), 32'd9);
    oe = 1'b1;
    row_addr = 4'd2;
    cyc(3);
    check("disp_on_after_rise", 32'(disp_on), 32'd0);
    check("disp_row_held", 32'(disp_row), 32'd9);
    oe = 1'b0;
    cyc(4);

    // Reset while the write-out is at column 12.
    row_addr = 4'd10;
    for (int k = 0; k < 32; k++) pixel(3'b111, 3'b110);
    base = n_ld;
    lat_pulse();
    cyc(13);
    reset = 1'b1;
    #1;
    check("reset_mid_write_outputs", all_outs(), 32'd0);
    cyc(3);
    reset = 1'b0;
    cyc(50);
    check("reset_no_line_done", 32'(n_ld - base), 32'd0);
    vecs.push_back('{5'd10, 5'd0, 3'b111});
    vecs.push_back('{5'd10, 5'd11, 3'b111});
    vecs.push_back('{5'd10, 5'd12, 3'b001});
    vecs.push_back('{5'd26, 5'd11, 3'b110});
    vecs.push_back('{5'd26, 5'd12, 3'b001});
    run_vecs("partial");

    // First latch after reset with no shifts: no len_err, writes cleared chains.
    row_addr = 4'd2;
    le0 = n_le;
    base = n_ld;
    lat_pulse();
    wait_ld(base, "first_latch_done");
    check("first_latch_no_len_err", 32'(n_le - le0), 32'd0);
    vecs.push_back('{5'd2, 5'd0, 3'b000});
    vecs.push_back('{5'd18, 5'd31, 3'b000});
    run_vecs("cleared");

    // A full line after reset writes correctly.
    row_addr = 4'd10;
    for (int k = 0; k < 32; k++) begin
      t = 5'(k);
      pixel(t[2:0] ^ 3'b011, t[2:0]);
    end
    base = n_ld;
    lat_pulse();
    wait_ld(base, "post_reset_line_done");
    check("post_reset_line_row", 32'(line_row), 32'd10);
    check("post_reset_frame_count", 32'(frame_count), 32'd0);
    for (int c = 0; c < 32; c++) begin
      t = 5'(31 - c);
      vecs.push_back('{5'd10, 5'(c), t[2:0] ^ 3'b011});
      vecs.push_back('{5'd26, 5'(c), t[2:0]});
    end
    run_vecs("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
